// File: rtl/psx_state_arbiter.sv
// psx_state_arbiter: shares the controller-state RAM write port between two
// burst requesters. One burst is granted at a time, round-robin on ties;
// accepted bytes become RAM writes with an auto-incrementing address.
//
//   state  | meaning
//   IDLE   | no owner; choose a requester and latch its start/len
//   STREAM | owner streams bytes; ends on last beat, request drop or timeout
module psx_state_arbiter #(
  parameter int ADDR_BITS    = 5,
  parameter int DATA_BITS    = 8,
  parameter int TIMEOUT_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic [ADDR_BITS-1:0] start0,
  input  logic [ADDR_BITS-1:0] len0,
  input  logic [DATA_BITS-1:0] data0,
  input  logic                 valid0,
  output logic                 ready0,
  output logic                 done0,
  input  logic                 req1,
  input  logic [ADDR_BITS-1:0] start1,
  input  logic [ADDR_BITS-1:0] len1,
  input  logic [DATA_BITS-1:0] data1,
  input  logic                 valid1,
  output logic                 ready1,
  output logic                 done1,
  output logic                 err,
  output logic [1:0]           grant,
  output logic [ADDR_BITS-1:0] write_addr,
  output logic [DATA_BITS-1:0] write_data,
  output logic                 write_en
);

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t                state;
  logic [ADDR_BITS-1:0]  addr_ptr;
  logic [ADDR_BITS-1:0]  remaining;
  logic [TIMEOUT_BITS-1:0] timer;
  logic                  owner;       // requester currently (or last) granted
  logic                  last_owner;  // requester that won the previous grant

  logic                  pick;
  logic [ADDR_BITS-1:0]  pick_start;
  logic [ADDR_BITS-1:0]  pick_len;
  logic                  own_req;
  logic                  own_valid;
  logic [DATA_BITS-1:0]  own_data;
  logic                  beat;
  logic                  last_beat;
  logic                  timed_out;

  // Requester selection in IDLE and owner-side input muxing in STREAM.
  always_comb begin
    pick       = (req0 && req1) ? ~last_owner : req1;
    pick_start = pick ? start1 : start0;
    pick_len   = pick ? len1 : len0;
    own_req    = owner ? req1 : req0;
    own_valid  = owner ? valid1 : valid0;
    own_data   = owner ? data1 : data0;
    beat       = (state == STREAM) && own_valid;
    last_beat  = (remaining == ADDR_BITS'(1));
    timed_out  = (timer == '0);
  end

  assign ready0 = (state == STREAM) && grant[0];
  assign ready1 = (state == STREAM) && grant[1];

  // Grant/stream FSM with registered RAM-write, done and err outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      err        <= 1'b0;
      write_en   <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      addr_ptr   <= '0;
      remaining  <= '0;
      timer      <= '0;
      owner      <= 1'b0;
      last_owner <= 1'b1;
    end else begin
      done0    <= 1'b0;
      done1    <= 1'b0;
      err      <= 1'b0;
      write_en <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner      <= pick;
            last_owner <= pick;
            addr_ptr   <= pick_start;
            remaining  <= pick_len;
            timer      <= '1;
            if (pick_len == '0) begin
              // empty burst completes immediately without touching the RAM
              done0 <= ~pick;
              done1 <= pick;
            end else begin
              state <= STREAM;
              grant <= pick ? 2'b10 : 2'b01;
            end
          end
        end
        STREAM: begin
          if (beat) begin
            write_en   <= 1'b1;
            write_addr <= addr_ptr;
            write_data <= own_data;
            addr_ptr   <= addr_ptr + ADDR_BITS'(1);
            remaining  <= remaining - ADDR_BITS'(1);
            timer      <= '1;
          end else if (!timed_out) begin
            timer <= timer - TIMEOUT_BITS'(1);
          end
          // a beat that completes the burst takes precedence over a request drop
          if ((beat && last_beat) || !own_req || (!beat && timed_out)) begin
            state <= IDLE;
            grant <= '0;
            done0 <= ~owner;
            done1 <= owner;
            err   <= !(beat && last_beat);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
